// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential restoring divider.
// Imported by the step datapath and the divider top level.
package div_pkg;

  localparam int DEF_WIDTH = 8;

  localparam int CNT_W = $clog2(2 * DEF_WIDTH);

  typedef enum logic {
    IDLE,
    RUN
  } div_state_e;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(2 * w) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift a dividend bit into the
// partial remainder, subtract the divisor when it fits.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_o
);

  logic [WIDTH+1:0] wide;
  logic [WIDTH+1:0] dvs_ext;

  assign wide    = {rem_i, bit_i};
  assign dvs_ext = {2'b00, divisor_i};
  assign q_o     = (wide >= dvs_ext);

  // The running remainder stays below the divisor, so the
  // result always fits back into WIDTH+1 bits.
  assign rem_o = q_o ? (WIDTH+1)'(wide - dvs_ext)
                     : (WIDTH+1)'(wide);

endmodule

// File: rtl/sequential_divider.sv
// Unsigned 2W/W restoring divider, one quotient bit per clock,
// sharing the start/ready handshake of the shift-add multiplier.
module sequential_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero
);

  localparam int CW = cnt_width(WIDTH);
  localparam int DW = 2 * WIDTH;

  div_state_e     state_q;
  logic [CW-1:0]  cnt_q;
  logic [WIDTH:0] rem_q;
  logic [DW-1:0]  dq_q;
  logic [WIDTH-1:0] dvs_q;
  logic [DW-1:0]  quo_q;
  logic [WIDTH-1:0] rmd_q;
  logic           dbz_q;
  logic           done_q;
  logic           ready_q;

  logic [WIDTH:0] rem_d;
  logic           qbit_d;
  logic [DW-1:0]  dq_d;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dq_q[DW-1]),
    .divisor_i (dvs_q),
    .rem_o     (rem_d),
    .q_o       (qbit_d)
  );

  // Dividend drains out the top while quotient bits fill the bottom.
  assign dq_d = {dq_q[DW-2:0], qbit_d};

  // Control FSM, working registers and registered results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dq_q    <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              done_q <= 1'b1;
              quo_q  <= '1;
              rmd_q  <= dividend[WIDTH-1:0];
              dbz_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              ready_q <= 1'b0;
              dvs_q   <= divisor;
              dq_q    <= dividend;
              rem_q   <= '0;
              cnt_q   <= CW'(DW - 1);
            end
          end
        end
        RUN: begin
          rem_q <= rem_d;
          dq_q  <= dq_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            quo_q   <= dq_d;
            rmd_q   <= rem_d[WIDTH-1:0];
            dbz_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready       = ready_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Scoreboard bench for sequential_divider at WIDTH=8.
// Expected results are queued at launch and popped on done.
module tb_sequential_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        ready;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  sequential_divider dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
    logic [15:0] a;
    logic [7:0]  b;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;
  int   t_acc;
  int   lat;
  bit   seen;

  task automatic push_exp(input logic [15:0] a, input logic [7:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 8'd0) begin
      e.q = 16'hFFFF;
      e.r = a[7:0];
      e.z = 1'b1;
    end else begin
      e.q = a / {8'd0, b};
      e.r = 8'(a % {8'd0, b});
      e.z = 1'b0;
    end
    sb.push_back(e);
  endtask

  task automatic launch(input logic [15:0] a, input logic [7:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    push_exp(a, b);
    @(posedge clk);
    #1;
    t_acc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done();
    while (!done && (cyc - t_acc) < 40) begin
      @(posedge clk);
      #1;
    end
    seen = done;
    lat  = cyc - t_acc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    #2 reset = 1'b0;
    #1;
    nvec++;
    if ({ready, done, quotient, remainder, div_by_zero} !== {2'b10, 16'd0, 8'd0, 1'b0}) begin
      nerr++;
      $display("FAIL reset_state: got r%b d%b q%0d r%0d z%b want r1 d0 q0 r0 z0",
               ready, done, quotient, remainder, div_by_zero);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    logic [15:0] ta [4] = '{16'd96, 16'd1000, 16'd65535, 16'd65535};
    logic [7:0]  tb [4] = '{8'd12, 8'd7, 8'd1, 8'd255};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      launch(ta[i], tb[i]);
      wait_done();
      e = sb.pop_front();
      nvec++;
      if (!seen) begin
        nerr++;
        $display("FAIL basic_timeout[%0d]: got no done want done", i);
      end
      nvec++;
      if (quotient !== e.q || remainder !== e.r || div_by_zero !== 1'b0) begin
        nerr++;
        $display("FAIL basic_result[%0d]: got %0d r%0d z%b want %0d r%0d z0",
                 i, quotient, remainder, div_by_zero, e.q, e.r);
      end
      nvec++;
      if (lat !== 16 || ready !== 1'b1) begin
        nerr++;
        $display("FAIL basic_latency[%0d]: got %0d rdy%b want 16 rdy1", i, lat, ready);
      end
      @(posedge clk);
      #1;
      nvec++;
      if (done !== 1'b0) begin
        nerr++;
        $display("FAIL basic_done_width[%0d]: got %b want 0", i, done);
      end
    end
  endtask

  task automatic test_div_zero();
    exp_t e;
    launch(16'd200, 8'd0);
    nvec++;
    if (ready !== 1'b1) begin
      nerr++;
      $display("FAIL dz_ready: got %b want 1", ready);
    end
    wait_done();
    e = sb.pop_front();
    nvec++;
    if (!seen || lat !== 0) begin
      nerr++;
      $display("FAIL dz_latency: got seen%b lat%0d want seen1 lat0", seen, lat);
    end
    nvec++;
    if (quotient !== e.q || remainder !== e.r || div_by_zero !== 1'b1) begin
      nerr++;
      $display("FAIL dz_result: got %0d r%0d z%b want %0d r%0d z1",
               quotient, remainder, div_by_zero, e.q, e.r);
    end
    @(posedge clk);
    #1;
    nvec++;
    if (done !== 1'b0 || ready !== 1'b1 || div_by_zero !== 1'b1) begin
      nerr++;
      $display("FAIL dz_after: got d%b rdy%b z%b want d0 rdy1 z1", done, ready, div_by_zero);
    end
    launch(16'd100, 8'd3);
    wait_done();
    e = sb.pop_front();
    nvec++;
    if (!seen || quotient !== e.q || remainder !== e.r || div_by_zero !== 1'b0) begin
      nerr++;
      $display("FAIL dz_clear: got %0d r%0d z%b want %0d r%0d z0",
               quotient, remainder, div_by_zero, e.q, e.r);
    end
  endtask

  task automatic test_ignore_start();
    exp_t e;
    launch(16'd120, 8'd4);
    repeat (3) @(posedge clk);
    @(negedge clk);
    dividend = 16'd30;
    divisor  = 8'd2;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    nvec++;
    if (ready !== 1'b0) begin
      nerr++;
      $display("FAIL ign_ready: got %b want 0", ready);
    end
    wait_done();
    e = sb.pop_front();
    nvec++;
    if (!seen || lat !== 16 || quotient !== e.q || remainder !== e.r) begin
      nerr++;
      $display("FAIL ign_result: got %0d r%0d lat%0d want %0d r%0d lat16",
               quotient, remainder, lat, e.q, e.r);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   ndone = 0;
    @(negedge clk);
    dividend = 16'd5000;
    divisor  = 8'd9;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    nvec++;
    if ({ready, done, quotient, remainder, div_by_zero} !== {2'b10, 16'd0, 8'd0, 1'b0}) begin
      nerr++;
      $display("FAIL rstmid_state: got r%b d%b q%0d r%0d z%b want r1 d0 q0 r0 z0",
               ready, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    nvec++;
    if (ndone !== 0 || ready !== 1'b1) begin
      nerr++;
      $display("FAIL rstmid_nodone: got %0d dones rdy%b want 0 rdy1", ndone, ready);
    end
    launch(16'd5000, 8'd9);
    wait_done();
    e = sb.pop_front();
    nvec++;
    if (!seen || lat !== 16 || quotient !== 16'd555 || remainder !== 8'd5) begin
      nerr++;
      $display("FAIL rstmid_rerun: got %0d r%0d lat%0d want 555 r5 lat16",
               quotient, remainder, lat);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    @(negedge clk);
    dividend = 16'd40000;
    divisor  = 8'd201;
    start    = 1'b1;
    push_exp(16'd40000, 8'd201);
    @(posedge clk);
    #1;
    t_acc = cyc;
    dividend = 16'd777;
    divisor  = 8'd13;
    wait_done();
    e = sb.pop_front();
    nvec++;
    if (!seen || lat !== 16 || quotient !== e.q || remainder !== e.r) begin
      nerr++;
      $display("FAIL b2b_first: got %0d r%0d lat%0d want %0d r%0d lat16",
               quotient, remainder, lat, e.q, e.r);
    end
    push_exp(16'd777, 8'd13);
    @(posedge clk);
    #1;
    t_acc = cyc;
    start = 1'b0;
    nvec++;
    if (ready !== 1'b0 || done !== 1'b0) begin
      nerr++;
      $display("FAIL b2b_accept: got rdy%b d%b want rdy0 d0", ready, done);
    end
    wait_done();
    e = sb.pop_front();
    nvec++;
    if (!seen || lat !== 16 || quotient !== e.q || remainder !== e.r) begin
      nerr++;
      $display("FAIL b2b_second: got %0d r%0d lat%0d want %0d r%0d lat16",
               quotient, remainder, lat, e.q, e.r);
    end
  endtask

  task automatic test_random();
    exp_t        e;
    logic [15:0] a;
    logic [7:0]  b;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = 8'($urandom_range(1, 255));
      launch(a, b);
      wait_done();
      e = sb.pop_front();
      nvec++;
      if (!seen || lat !== 16) begin
        nerr++;
        $display("FAIL rnd_latency[%0d]: got seen%b lat%0d want lat16", i, seen, lat);
      end
      nvec++;
      if (quotient !== e.q || remainder !== e.r || div_by_zero !== 1'b0) begin
        nerr++;
        $display("FAIL rnd_result[%0d] %0d/%0d: got %0d r%0d want %0d r%0d",
                 i, e.a, e.b, quotient, remainder, e.q, e.r);
      end
      nvec++;
      if (32'(quotient) * 32'(e.b) + 32'(remainder) !== 32'(e.a) || remainder >= e.b) begin
        nerr++;
        $display("FAIL rnd_invariant[%0d] %0d/%0d: got %0d r%0d", i, e.a, e.b,
                 quotient, remainder);
      end
      @(posedge clk);
      #1;
      nvec++;
      if (done !== 1'b0) begin
        nerr++;
        $display("FAIL rnd_done_width[%0d]: got %b want 0", i, done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    nvec++;
    if (sb.size() !== 0) begin
      nerr++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
